// File: rtl/softmax_job_sched_if.sv
// Descriptor handshake between the host requester and the job scheduler.
// master: host (drives valid/addresses); slave: scheduler (drives ready).
interface softmax_job_sched_if #(
  parameter int ADDRSIZE = 8
) ();
  logic                job_valid;
  logic                job_ready;
  logic [ADDRSIZE-1:0] job_start_addr;
  logic [ADDRSIZE-1:0] job_end_addr;

  modport master (
    output job_valid,
    output job_start_addr,
    output job_end_addr,
    input  job_ready
  );

  modport slave (
    input  job_valid,
    input  job_start_addr,
    input  job_end_addr,
    output job_ready
  );
endinterface

// File: rtl/softmax_job_sched.sv
// Job scheduler: buffers softmax descriptors, runs them one at a time.
// Ports: clk, reset (sync, active-high); job (descriptor handshake,
// slave side); sm_* engine controls/done; job_done/job_err pulses;
// busy; q_count (FIFO occupancy). Optional watchdog:
// define SOFTMAX_SCHED_TIMEOUT_EN to enable (sm_rst pulses on timeout).
module softmax_job_sched #(
  parameter int ADDRSIZE       = 8,
  parameter int QDEPTH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  softmax_job_sched_if.slave           job,
  output logic [ADDRSIZE-1:0]          sm_start_addr,
  output logic [ADDRSIZE-1:0]          sm_end_addr,
  output logic                         sm_init,
  output logic                         sm_start,
  output logic                         sm_rst,
  input  logic                         sm_done,
  output logic                         job_done,
  output logic                         job_err,
  output logic                         busy,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam int BW = ADDRSIZE + 1;

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("softmax_job_sched: bad QDEPTH/TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, CHECK, GAP
  } state_t;

  state_t state, state_n;

  logic [ADDRSIZE-1:0] q_start [QDEPTH];
  logic [ADDRSIZE-1:0] q_end   [QDEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_n;
  logic [BW-1:0]       beats;
  logic                done_q;

  logic accept, push, bad, pop, fall, len_ok, wd_hit;
  logic init_n, start_n, done_n, err_n, rst_p;

  assign job.job_ready = q_count < CW'(QDEPTH);
  assign accept = job.job_valid & job.job_ready;
  assign push   = accept &
                  (job.job_end_addr > job.job_start_addr);
  assign bad    = accept &
                  ~(job.job_end_addr > job.job_start_addr);
  // count is registered, so a fresh push is only visible next cycle
  assign pop    = (state == IDLE) & (q_count != '0);
  // done_q only tracks sm_done while in RUN
  assign fall   = done_q & ~sm_done;
  assign len_ok = beats == {1'b0, sm_end_addr - sm_start_addr};

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  // wd_cnt is k-1 in the k-th RUN cycle
  assign wd_hit = wd_cnt == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset || state != RUN) wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    count_n = q_count;
    if (push & ~pop)      count_n = q_count + 1'b1;
    else if (pop & ~push) count_n = q_count - 1'b1;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = bad;
    rst_p   = 1'b0;
    unique case (state)
      IDLE:  if (pop) state_n = LOAD;
      LOAD:  state_n = START;
      START: state_n = RUN;
      RUN: begin
        if (fall) begin
          state_n = CHECK;
          done_n  = 1'b1;
          if (!len_ok) err_n = 1'b1;
        end else if (wd_hit) begin
          state_n = GAP;
          err_n   = 1'b1;
          rst_p   = 1'b1;
        end
      end
      CHECK: state_n = GAP;
      GAP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    init_n  = state_n == LOAD;
    start_n = state_n == START;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_start[wr_ptr] <= job.job_start_addr;
      q_end[wr_ptr]   <= job.job_end_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_count       <= '0;
      sm_start_addr <= '0;
      sm_end_addr   <= '0;
      sm_init       <= 1'b0;
      sm_start      <= 1'b0;
      sm_rst        <= 1'b0;
      job_done      <= 1'b0;
      job_err       <= 1'b0;
      busy          <= 1'b0;
      beats         <= '0;
      done_q        <= 1'b0;
    end else begin
      state    <= state_n;
      q_count  <= count_n;
      sm_init  <= init_n;
      sm_start <= start_n;
      sm_rst   <= rst_p;
      job_done <= done_n;
      job_err  <= err_n;
      busy     <= (state_n != IDLE) || (count_n != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // addresses stay put until the next pop
      if (pop) begin
        sm_start_addr <= q_start[rd_ptr];
        sm_end_addr   <= q_end[rd_ptr];
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (state == START) begin
        beats  <= '0;
        done_q <= 1'b0;
      end else if (state == RUN) begin
        done_q <= sm_done;
        if (sm_done && beats != '1) beats <= beats + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_softmax_job_sched.sv
// Self-checking bench for softmax_job_sched: random jobs, an engine
// model and a descriptor scoreboard kept in queues.
module tb_softmax_job_sched;
  localparam int AW = 8;
  localparam int QD = 4;
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int CW = $clog2(QD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] sm_start_addr, sm_end_addr;
  logic          sm_init, sm_start, sm_rst;
  logic          sm_done = 1'b0;
  logic          job_done, job_err, busy;
  logic [CW-1:0] q_count;

  softmax_job_sched_if #(.ADDRSIZE(AW)) job ();

  softmax_job_sched #(
    .ADDRSIZE(AW), .QDEPTH(QD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .job(job),
    .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
    .sm_init(sm_init), .sm_start(sm_start), .sm_rst(sm_rst),
    .sm_done(sm_done), .job_done(job_done), .job_err(job_err),
    .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fifo_n = 0;

  logic [AW-1:0] offer_s[$], offer_e[$], exp_s[$], exp_e[$];
  int            offer_gap[$], acc_c[$], exp_err_c[$];
  int            init_c[$], start_c[$], done_c[$];
  int            err_c[$], rst_c[$], fall_c[$];
  logic [AW-1:0] init_s[$], init_e[$], done_s[$], done_e[$];
  bit            done_err[$], exp_derr[$];

  int eng_wait = 0;
  int eng_left = 0;
  bit fall_pending = 0;
  int short_mode = 0;
  int fixed_short = 0;
  bit silent_first = 0;
  bit saw_full = 0;
  int qc_mis = 0;
  int qc_act = 0;
  int qc_exp = 0;

  task automatic clear_logs();
    offer_s.delete(); offer_e.delete(); offer_gap.delete();
    exp_s.delete(); exp_e.delete(); acc_c.delete();
    exp_err_c.delete(); init_c.delete(); start_c.delete();
    done_c.delete(); err_c.delete(); rst_c.delete();
    fall_c.delete(); init_s.delete(); init_e.delete();
    done_s.delete(); done_e.delete(); done_err.delete();
    exp_derr.delete();
    qc_mis = 0; saw_full = 0;
  endtask

  // One clock: log DUT events, then drive the engine model.
  task automatic cycle();
    int idx, len;
    bit mis;
    @(negedge clk);
    cyc++;
    if (sm_init === 1'b1) begin
      init_c.push_back(cyc);
      init_s.push_back(sm_start_addr);
      init_e.push_back(sm_end_addr);
      if (fifo_n > 0) fifo_n--;
    end
    if (sm_start === 1'b1) begin
      idx = start_c.size();
      start_c.push_back(cyc);
      len = 1;
      if (idx < exp_s.size())
        len = int'(exp_e[idx]) - int'(exp_s[idx]);
      mis = 0;
      if (short_mode == 1) begin
        len -= fixed_short;
        mis = (fixed_short != 0);
      end else if (short_mode == 2 &&
                   $urandom_range(0, 3) == 0) begin
        if (len > 1 && $urandom_range(0, 1) == 1) len -= 1;
        else len += 1;
        mis = 1;
      end
      if (silent_first && idx == 0) len = 0;
      exp_derr.push_back(mis);
      eng_wait = $urandom_range(1, 3);
      eng_left = len;
    end
    if (job_done === 1'b1) begin
      done_c.push_back(cyc);
      done_err.push_back(job_err);
      done_s.push_back(sm_start_addr);
      done_e.push_back(sm_end_addr);
    end else if (job_err === 1'b1) begin
      err_c.push_back(cyc);
    end
    if (sm_rst === 1'b1) rst_c.push_back(cyc);
    if (eng_wait > 0) begin
      eng_wait--;
      sm_done = 1'b0;
    end else if (eng_left > 0) begin
      sm_done = 1'b1;
      eng_left--;
      if (eng_left == 0) fall_pending = 1;
    end else begin
      if (fall_pending) begin
        fall_c.push_back(cyc);
        fall_pending = 0;
      end
      sm_done = 1'b0;
    end
  endtask

  // Offer queued descriptors and step until everything drains.
  task automatic drive(input int maxcyc, input bit stop_on_start,
                       output bit tmo);
    int k, gap_left, n, settle, outst;
    k = 0; n = 0; settle = 0; tmo = 0;
    gap_left = (offer_gap.size() > 0) ? offer_gap[0] : 0;
    forever begin
      cycle();
      n++;
      if (q_count !== CW'(fifo_n) ||
          job.job_ready !== (fifo_n < QD)) begin
        if (qc_mis == 0) begin
          qc_act = int'(q_count);
          qc_exp = fifo_n;
        end
        qc_mis++;
      end
      if (fifo_n == QD && job.job_ready === 1'b0) saw_full = 1;
      if (stop_on_start && start_c.size() > 0) begin
        job.job_valid = 1'b0;
        break;
      end
      outst = init_c.size() - done_c.size() - rst_c.size();
      if (k >= offer_s.size() && fifo_n == 0 && outst == 0) begin
        settle++;
        if (settle > 3) break;
      end
      if (n >= maxcyc) begin
        tmo = 1;
        job.job_valid = 1'b0;
        break;
      end
      job.job_valid = 1'b0;
      if (k < offer_s.size()) begin
        if (gap_left > 0) begin
          gap_left--;
        end else begin
          job.job_valid = 1'b1;
          job.job_start_addr = offer_s[k];
          job.job_end_addr = offer_e[k];
          if (fifo_n < QD) begin
            acc_c.push_back(cyc);
            if (offer_e[k] > offer_s[k]) begin
              fifo_n++;
              exp_s.push_back(offer_s[k]);
              exp_e.push_back(offer_e[k]);
            end else begin
              exp_err_c.push_back(cyc + 1);
            end
            k++;
            if (k < offer_s.size()) gap_left = offer_gap[k];
          end
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    job.job_valid = 1'b0;
    eng_left = 0; eng_wait = 0; fall_pending = 0;
    sm_done = 1'b0;
    repeat (n) cycle();
    reset = 1'b0;
    eng_left = 0; eng_wait = 0; fall_pending = 0;
    fifo_n = 0;
  endtask

  task automatic add_job(input int s, input int e, input int gap);
    offer_s.push_back(AW'(s));
    offer_e.push_back(AW'(e));
    offer_gap.push_back(gap);
  endtask

  task automatic test_reset();
    job.job_valid = 1'b0;
    job.job_start_addr = '0;
    job.job_end_addr = '0;
    do_reset(3);
    checks++;
    if (job.job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", job.job_ready);
    end
    checks++;
    if (q_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_count_busy: got %0d/%b want 0/0",
               q_count, busy);
    end
    checks++;
    if ({sm_init, sm_start, sm_rst, job_done, job_err} !== 5'b0)
    begin
      errors++;
      $display("FAIL reset_pulses: got %b want 00000",
               {sm_init, sm_start, sm_rst, job_done, job_err});
    end
    checks++;
    if (sm_start_addr !== '0 || sm_end_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h want 00/00",
               sm_start_addr, sm_end_addr);
    end
  endtask

  task automatic test_single();
    bit tmo;
    clear_logs();
    short_mode = 0;
    add_job('h10, 'h14, 0);
    drive(200, 0, tmo);
    checks++;
    if (tmo || init_c.size() != 1 || done_c.size() != 1 ||
        fall_c.size() != 1) begin
      errors++;
      $display("FAIL single_flow: tmo=%0d inits=%0d dones=%0d want 0/1/1",
               tmo, init_c.size(), done_c.size());
    end else begin
      checks++;
      if (init_c[0] != acc_c[0] + 2 ||
          start_c[0] != acc_c[0] + 3) begin
        errors++;
        $display("FAIL single_latency: init %0d start %0d want %0d %0d",
                 init_c[0], start_c[0], acc_c[0] + 2, acc_c[0] + 3);
      end
      checks++;
      if (init_s[0] !== 8'h10 || init_e[0] !== 8'h14 ||
          done_s[0] !== 8'h10 || done_e[0] !== 8'h14) begin
        errors++;
        $display("FAIL single_addr: got %h/%h %h/%h want 10/14",
                 init_s[0], init_e[0], done_s[0], done_e[0]);
      end
      checks++;
      if (done_c[0] != fall_c[0] + 1 || done_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_done: at %0d err %b want %0d err 0",
                 done_c[0], done_err[0], fall_c[0] + 1);
      end
    end
    checks++;
    if (qc_mis != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_count: q_count %0d want %0d busy %b want 0",
               qc_act, qc_exp, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    int s;
    clear_logs();
    short_mode = 0;
    add_job('h00, 'h0C, 0);
    for (int i = 0; i < 5; i++) begin
      s = $urandom_range(1, 200);
      add_job(s, s + $urandom_range(1, 10), 0);
    end
    drive(800, 0, tmo);
    checks++;
    if (tmo || saw_full != 1 || qc_mis != 0) begin
      errors++;
      $display("FAIL b2b_fill: tmo=%0d full=%0d q %0d want %0d",
               tmo, saw_full, qc_act, qc_exp);
    end
    checks++;
    if (init_c.size() != 6 || done_c.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: inits %0d dones %0d want 6/6",
               init_c.size(), done_c.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (init_s[i] !== exp_s[i] || init_e[i] !== exp_e[i] ||
            done_s[i] !== exp_s[i] || done_err[i] !== 1'b0 ||
            done_c[i] != fall_c[i] + 1) begin
          errors++;
          $display("FAIL b2b_job%0d: got %h-%h err %b want %h-%h err 0",
                   i, init_s[i], init_e[i], done_err[i],
                   exp_s[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_bad_desc();
    bit tmo;
    clear_logs();
    add_job('h20, 'h20, 0);
    add_job('h30, 'h10, 2);
    drive(50, 0, tmo);
    checks++;
    if (tmo || err_c.size() != 2 || exp_err_c.size() != 2) begin
      errors++;
      $display("FAIL bad_errs: tmo=%0d errs %0d want 2",
               tmo, err_c.size());
    end else begin
      checks++;
      if (err_c[0] != exp_err_c[0] || err_c[1] != exp_err_c[1]) begin
        errors++;
        $display("FAIL bad_timing: at %0d,%0d want %0d,%0d",
                 err_c[0], err_c[1], exp_err_c[0], exp_err_c[1]);
      end
    end
    checks++;
    if (init_c.size() != 0 || done_c.size() != 0 || qc_mis != 0)
    begin
      errors++;
      $display("FAIL bad_noqueue: inits %0d dones %0d q %0d want 0/0/%0d",
               init_c.size(), done_c.size(), qc_act, qc_exp);
    end
  endtask

  task automatic test_mismatch();
    bit tmo;
    clear_logs();
    short_mode = 1;
    fixed_short = 2;
    add_job('h00, 'h08, 0);
    drive(200, 0, tmo);
    short_mode = 0;
    checks++;
    if (tmo || done_c.size() != 1 || fall_c.size() != 1) begin
      errors++;
      $display("FAIL mis_flow: tmo=%0d dones %0d want 1",
               tmo, done_c.size());
    end else begin
      checks++;
      if (done_err[0] !== 1'b1 || done_c[0] != fall_c[0] + 1 ||
          err_c.size() != 0) begin
        errors++;
        $display("FAIL mis_err: err %b at %0d want 1 at %0d",
                 done_err[0], done_c[0], fall_c[0] + 1);
      end
    end
  endtask

  task automatic test_random();
    bit tmo;
    int s;
    int nj;
    clear_logs();
    short_mode = 2;
    nj = 16;
    for (int i = 0; i < nj; i++) begin
      s = $urandom_range(0, 200);
      add_job(s, s + $urandom_range(1, 10), $urandom_range(0, 4));
    end
    drive(3000, 0, tmo);
    short_mode = 0;
    checks++;
    if (tmo || init_c.size() != nj || done_c.size() != nj ||
        qc_mis != 0 || rst_c.size() != 0) begin
      errors++;
      $display("FAIL rand_flow: tmo=%0d inits %0d dones %0d q %0d/%0d",
               tmo, init_c.size(), done_c.size(), qc_act, qc_exp);
    end else begin
      for (int i = 0; i < nj; i++) begin
        checks++;
        if (init_s[i] !== exp_s[i] || init_e[i] !== exp_e[i] ||
            done_err[i] !== exp_derr[i] ||
            done_c[i] != fall_c[i] + 1) begin
          errors++;
          $display("FAIL rand_job%0d: got %h-%h err %b want %h-%h err %b",
                   i, init_s[i], init_e[i], done_err[i],
                   exp_s[i], exp_e[i], exp_derr[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit tmo;
    clear_logs();
    add_job('h00, 'h0C, 0);
    add_job('h10, 'h1C, 0);
    add_job('h20, 'h2C, 0);
    drive(50, 1, tmo);
    repeat (3) cycle();
    checks++;
    if (tmo || q_count !== CW'(fifo_n) || fifo_n != 2 ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre: q %0d busy %b want 2/1", q_count, busy);
    end
    do_reset(1);
    checks++;
    if (q_count !== '0 || busy !== 1'b0 ||
        job.job_ready !== 1'b1) begin
      errors++;
      $display("FAIL mrst_post: q %0d busy %b rdy %b want 0/0/1",
               q_count, busy, job.job_ready);
    end
    repeat (40) cycle();
    checks++;
    if (done_c.size() != 0 || init_c.size() != 1 ||
        err_c.size() != 0) begin
      errors++;
      $display("FAIL mrst_abort: dones %0d inits %0d errs %0d want 0/1/0",
               done_c.size(), init_c.size(), err_c.size());
    end
  endtask

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit tmo;
    clear_logs();
    silent_first = 1;
    add_job('h40, 'h44, 0);
    add_job('h50, 'h53, 0);
    drive(300, 0, tmo);
    silent_first = 0;
    checks++;
    if (tmo || rst_c.size() != 1 || start_c.size() < 1) begin
      errors++;
      $display("FAIL tmo_flow: tmo=%0d rsts %0d want 1",
               tmo, rst_c.size());
    end else begin
      checks++;
      if (rst_c[0] != start_c[0] + TMO + 1 || err_c.size() != 1 ||
          err_c[0] != rst_c[0]) begin
        errors++;
        $display("FAIL tmo_pulse: rst at %0d errs %0d want at %0d",
                 rst_c[0], err_c.size(), start_c[0] + TMO + 1);
      end
      checks++;
      if (init_c.size() != 2 || done_c.size() != 1) begin
        errors++;
        $display("FAIL tmo_next: inits %0d dones %0d want 2/1",
                 init_c.size(), done_c.size());
      end else begin
        checks++;
        if (init_c[1] != rst_c[0] + 2 || init_s[1] !== 8'h50 ||
            done_err[0] !== 1'b0) begin
          errors++;
          $display("FAIL tmo_job2: init %0d addr %h want %0d addr 50",
                   init_c[1], init_s[1], rst_c[0] + 2);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_desc();
    test_mismatch();
    test_random();
    test_mid_reset();
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
